mem_stage_access: RTL and testbench

//  Consumer end of the 173-bit EX/MEM pipeline bus: unpacks it, runs the data-memory access over a
//  req/ack handshake, and builds the 71-bit MEM/WB bus.

---
 rtl/mem_stage_access.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage_access.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// Purpose : MEM pipeline stage. Unpacks the EX/MEM bus, performs the data-memory
//           access over a req/ack handshake and registers the MEM/WB bus.
// Latency : 1 cycle for non-memory ops; memory ops take 2+ cycles (req in IDLE, ack in BUSY).
// Backpr. : Stall holds upstream while an access is outstanding; a BUSY access with no
//           ack for TIMEOUT_CYCLES cycles is aborted, and bus_err pulses once.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   EX_MEM_in[172:0]  {WB,MEM,PC4,RD1,BT,Brc,ALU,RD2,rd}
//   dmem_*            data-memory request/ack interface (word address, byte enables)
//   Stall             upstream must hold EX_MEM_in this edge
//   bus_err           one-cycle pulse after an access times out
//   MEM_WB_out[70:0]  registered {WB,load_data,ALU,rd}
//   mem_misalign      (only with MEM_MISALIGN_TRAP_EN) registered pulse on a trapped access
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses are not issued, flagged on mem_misalign
//   undefined : low address bits are ignored per lane rules, every access issues

module mem_stage_access #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [172:0] EX_MEM_in,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [3:0]   dmem_be,
  output logic [31:0]  dmem_wdata,
  input  logic         dmem_ack,
  input  logic [31:0]  dmem_rdata,
  output logic         Stall,
  output logic         bus_err,
  output logic [70:0]  MEM_WB_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic         mem_misalign
`endif
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Bus fields
  logic [1:0]  wb;
  logic [4:0]  mem;
  logic [31:0] alu;
  logic [31:0] rd2;
  logic [4:0]  rd;

  assign wb  = EX_MEM_in[172:171];
  assign mem = EX_MEM_in[170:166];
  assign alu = EX_MEM_in[68:37];
  assign rd2 = EX_MEM_in[36:5];
  assign rd  = EX_MEM_in[4:0];

  // PC4, RD1, BT and Brc belong to other stages.
  logic unused_fields;
  assign unused_fields = ^EX_MEM_in[165:69];

  logic       mem_read, mem_write, load_sext, access;
  logic [1:0] size;
  logic [1:0] a;

  assign mem_read  = mem[4];
  assign mem_write = mem[3];
  assign size      = mem[2:1];
  assign load_sext = mem[0];
  assign access    = mem_read | mem_write;
  assign a         = alu[1:0];

  // Misaligned-access trap
  logic trap;
`ifdef MEM_MISALIGN_TRAP_EN
  // Byte is always aligned; reserved size 11 behaves as word.
  assign trap = access & (((size == 2'b01) & a[0]) |
                          (((size == 2'b00) | (size == 2'b11)) & (a != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  logic issue;
  assign issue = access & ~trap;

  // Store lanes and load extraction
  logic [3:0]  store_be;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    store_be   = 4'b1111;
    dmem_wdata = rd2;
    case (size)
      2'b10: begin
        store_be   = 4'b0001 << a;
        dmem_wdata = {4{rd2[7:0]}};
      end
      2'b01: begin
        store_be   = a[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{rd2[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        dmem_wdata = rd2;
      end
    endcase
  end

  // Both MemRead and MemWrite set is a store.
  assign dmem_we   = mem_write;
  assign dmem_be   = mem_write ? store_be : 4'b1111;
  assign dmem_addr = {alu[31:2], 2'b00};

  always_comb begin
    byte_sel  = 8'h00;
    load_data = dmem_rdata;
    case (a)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size)
      2'b10:   load_data = {{24{load_sext & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{load_sext & half_sel[15]}}, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // FSM
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [70:0]   mw_nxt;
  logic          err_nxt;
  logic          req_c, stall_c;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mw_nxt    = '0;  // bubble unless a result is ready
    err_nxt   = 1'b0;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue) begin
          req_c     = 1'b1;
          stall_c   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_BUSY;
        end else if (!trap) begin
          mw_nxt = {wb, 32'b0, alu, rd};
        end
      end
      S_BUSY: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          mw_nxt    = {wb, (mem_write ? 32'b0 : load_data), alu, rd};
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          // Abort: let the instruction retire with zero data so the core moves on.
          mw_nxt    = {wb, 32'b0, alu, rd};
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Held low during reset so an abandoned request is never presented.
  assign dmem_req = req_c & ~RST;
  assign Stall    = stall_c & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      MEM_WB_out <= '0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      MEM_WB_out <= mw_nxt;
      bus_err    <= err_nxt;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RST) mem_misalign <= 1'b0;
    else     mem_misalign <= (state == S_IDLE) & trap;
  end
`endif

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.
module tb_mem_stage_access;

  logic         CLK = 1'b0;
  logic         RST;
  logic [172:0] EX_MEM_in;
  logic         dmem_req, dmem_we;
  logic [31:0]  dmem_addr;
  logic [3:0]   dmem_be;
  logic [31:0]  dmem_wdata;
  logic         dmem_ack;
  logic [31:0]  dmem_rdata;
  logic         Stall, bus_err;
  logic [70:0]  MEM_WB_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic         mem_misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_stage_access #(.TIMEOUT_CYCLES(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EX_MEM_in  (EX_MEM_in),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .Stall      (Stall),
    .bus_err    (bus_err),
    .MEM_WB_out (MEM_WB_out)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .mem_misalign (mem_misalign)
`endif
  );

  task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Unused fields carry junk so mis-sliced fields show up.
  function automatic logic [172:0] mk(input logic [1:0] wb, input logic [4:0] mem,
                                      input logic [31:0] alu, input logic [31:0] rd2,
                                      input logic [4:0] rd);
    return {wb, mem, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1, alu, rd2, rd};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One memory access: `waits` BUSY cycles without ack, then ack with rdata_v.
  task automatic run_access(input string tag, input logic [172:0] ex, input int waits,
                            input logic [31:0] rdata_v, input logic exp_we,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [70:0] exp_mw);
    int n_stall;
    int n_bad;
    n_stall = 0;
    n_bad   = 0;
    step();
    EX_MEM_in = ex;
    dmem_ack  = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      @(negedge CLK);
      if (Stall && dmem_req) n_stall++;
      if (i > 0 && MEM_WB_out !== 71'd0) n_bad++;
      step();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata_v;
    @(negedge CLK);
    check({tag, "_ack_stall"}, 71'(Stall), 71'd0);
    check({tag, "_ack_req"},   71'(dmem_req), 71'd1);
    check({tag, "_we"},        71'(dmem_we), 71'(exp_we));
    check({tag, "_addr"},      71'(dmem_addr), 71'(exp_addr));
    check({tag, "_be"},        71'(dmem_be), 71'(exp_be));
    check({tag, "_wdata"},     71'(dmem_wdata), 71'(exp_wdata));
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    EX_MEM_in  = mk(2'b00, 5'b0, 32'h0, 32'h0, 5'd0);
    @(negedge CLK);
    check({tag, "_stall_cycles"}, 71'(n_stall), 71'(waits + 1));
    check({tag, "_bubbles"},      71'(n_bad), 71'd0);
    check({tag, "_mem_wb"},       MEM_WB_out, exp_mw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  done;
    logic [172:0] nop;
    nop = mk(2'b00, 5'b0, 32'h0, 32'h0, 5'd0);

    // Reset with an access pending on the bus: nothing may be requested.
    RST        = 1'b1;
    EX_MEM_in  = mk(2'b10, 5'b10000, 32'h100, 32'h0, 5'd1);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_req",     71'(dmem_req), 71'd0);
    check("rst_stall",   71'(Stall), 71'd0);
    check("rst_mem_wb",  MEM_WB_out, 71'd0);
    check("rst_bus_err", 71'(bus_err), 71'd0);
    step();
    RST       = 1'b0;
    EX_MEM_in = nop;

    // ALU op passes through with one cycle latency.
    step();
    EX_MEM_in = mk(2'b11, 5'b0, 32'h1234, 32'h0, 5'd7);
    @(negedge CLK);
    check("alu_stall", 71'(Stall), 71'd0);
    check("alu_req",   71'(dmem_req), 71'd0);
    step();
    EX_MEM_in = nop;
    @(negedge CLK);
    check("alu_mem_wb", MEM_WB_out, {2'b11, 32'h0, 32'h1234, 5'd7});
    check("alu_stall2", 71'(Stall), 71'd0);

    // Word load, ack after 3 BUSY cycles.
    run_access("wld", mk(2'b10, 5'b10000, 32'h100, 32'h0, 5'd3), 3, 32'hDEADBEEF,
               1'b0, 32'h100, 4'hF, 32'h0, {2'b10, 32'hDEADBEEF, 32'h100, 5'd3});
    // Signed / unsigned byte loads from lane 3.
    run_access("sb_ld", mk(2'b11, 5'b10101, 32'h103, 32'h0, 5'd4), 0, 32'h80123456,
               1'b0, 32'h100, 4'hF, 32'h0, {2'b11, 32'hFFFFFF80, 32'h103, 5'd4});
    run_access("ub_ld", mk(2'b11, 5'b10100, 32'h103, 32'h0, 5'd4), 1, 32'h80123456,
               1'b0, 32'h100, 4'hF, 32'h0, {2'b11, 32'h00000080, 32'h103, 5'd4});
    // Half loads: signed upper half, unsigned lower half.
    run_access("sh_ld", mk(2'b10, 5'b10011, 32'h102, 32'h0, 5'd11), 0, 32'h80011234,
               1'b0, 32'h100, 4'hF, 32'h0, {2'b10, 32'hFFFF8001, 32'h102, 5'd11});
    run_access("uh_ld", mk(2'b10, 5'b10010, 32'h100, 32'h0, 5'd11), 0, 32'h1234F00D,
               1'b0, 32'h100, 4'hF, 32'h0, {2'b10, 32'h0000F00D, 32'h100, 5'd11});
    // Half store to upper half.
    run_access("sh_st", mk(2'b01, 5'b01010, 32'h102, 32'h0000ABCD, 5'd9), 2, 32'hFFFFFFFF,
               1'b1, 32'h100, 4'b1100, 32'hABCDABCD, {2'b01, 32'h0, 32'h102, 5'd9});
    // Byte store to lane 1.
    run_access("sb_st", mk(2'b00, 5'b01100, 32'h101, 32'h1234565A, 5'd10), 0, 32'hFFFFFFFF,
               1'b1, 32'h100, 4'b0010, 32'h5A5A5A5A, {2'b00, 32'h0, 32'h101, 5'd10});
    // Read+write together is a word store.
    run_access("rw_st", mk(2'b11, 5'b11000, 32'h104, 32'hCAFEF00D, 5'd12), 1, 32'h99999999,
               1'b1, 32'h104, 4'hF, 32'hCAFEF00D, {2'b11, 32'h0, 32'h104, 5'd12});

    // Timeout: never ack; 1 IDLE + 7 BUSY stall cycles, released in the 8th BUSY cycle.
    step();
    EX_MEM_in = mk(2'b10, 5'b10000, 32'h200, 32'h0, 5'd5);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge CLK);
      if (Stall) n++;
      else done = 1'b1;
      if (!done) step();
    end
    check("to_released", 71'(done), 71'd1);
    check("to_stall_cycles", 71'(n), 71'd8);
    check("to_req_last", 71'(dmem_req), 71'd1);
    check("to_err_early", 71'(bus_err), 71'd0);
    step();
    EX_MEM_in = nop;
    @(negedge CLK);
    check("to_bus_err", 71'(bus_err), 71'd1);
    check("to_mem_wb", MEM_WB_out, {2'b10, 32'h0, 32'h200, 5'd5});
    step();
    @(negedge CLK);
    check("to_bus_err_end", 71'(bus_err), 71'd0);

    // Reset during BUSY abandons the request; a late ack is ignored.
    step();
    EX_MEM_in = mk(2'b10, 5'b10000, 32'h300, 32'h0, 5'd6);
    @(negedge CLK);
    check("rb_req_idle", 71'(dmem_req), 71'd1);
    step();
    @(negedge CLK);
    check("rb_req_busy", 71'(dmem_req), 71'd1);
    step();
    RST = 1'b1;
    step();
    RST        = 1'b0;
    EX_MEM_in  = mk(2'b01, 5'b0, 32'h55, 32'h0, 5'd2);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge CLK);
    check("rb_req",    71'(dmem_req), 71'd0);
    check("rb_stall",  71'(Stall), 71'd0);
    check("rb_mem_wb", MEM_WB_out, 71'd0);
    step();
    dmem_ack  = 1'b0;
    EX_MEM_in = nop;
    @(negedge CLK);
    check("rb_late_ack", MEM_WB_out, {2'b01, 32'h0, 32'h55, 5'd2});
    check("rb_req_after", 71'(dmem_req), 71'd0);
    check("rb_bus_err", 71'(bus_err), 71'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    step();
    EX_MEM_in = mk(2'b10, 5'b10000, 32'h101, 32'h0, 5'd1);
    @(negedge CLK);
    check("mis_req",   71'(dmem_req), 71'd0);
    check("mis_stall", 71'(Stall), 71'd0);
    step();
    EX_MEM_in = nop;
    @(negedge CLK);
    check("mis_pulse",  71'(mem_misalign), 71'd1);
    check("mis_mem_wb", MEM_WB_out, 71'd0);
    step();
    @(negedge CLK);
    check("mis_pulse_end", 71'(mem_misalign), 71'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
